// File: rtl/ram_latency_model.sv
// Word-addressed RAM responder for the cpu_ram_if bus with a programmable BUSY latency.
// Requests are latched, held in BUSY for LAT cycles, then completed with a one-cycle ACCESS.

package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module ram_latency_model
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 8192,
    parameter int LAT   = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output ramstate_t   ramstate
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT4    = 4'(LAT);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    ramstate_t   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  req_q, req_d;      // {read, write} of the latched request
    logic [31:0] store_q, store_d;
    logic [31:0] load_q;

    logic        req_any;
    logic        legal;
    logic        changed;
    logic        start;
    logic        mem_we;
    logic        load_en;
    logic [AW-1:0] acc_idx;

    // NOTE: the array has no reset; contents survive nRST and start at zero from the
    // declaration initialiser, which FPGA tools map into the block-RAM init image.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    assign req_any = ramREN | ramWEN;
    assign legal   = !(ramREN && ramWEN)
                     && (ramaddr[1:0] == 2'b00)
                     && (ramaddr[31:2] < DEPTH_W);

    // Store data only matters for a write; an illegal request always differs from the latch.
    assign changed = (ramaddr != addr_q)
                     || ({ramREN, ramWEN} != req_q)
                     || (ramWEN && (ramstore != store_q));

    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        req_d   = req_q;
        store_d = store_q;
        start   = 1'b0;
        mem_we  = 1'b0;
        load_en = 1'b0;

        unique case (state_q)
            BUSY: begin
                if (!req_any) begin
                    state_d = FREE;
                end else if (changed) begin
                    if (!legal) state_d = ERROR;
                    else        start   = 1'b1;
                end else begin
                    cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                    if (cnt_d == 4'd0) state_d = ACCESS;
                end
            end
            default: begin
                // FREE, ACCESS and ERROR all treat the sampled inputs as a fresh request.
                if (!req_any)    state_d = FREE;
                else if (!legal) state_d = ERROR;
                else             start   = 1'b1;
            end
        endcase

        if (start) begin
            addr_d  = ramaddr;
            req_d   = {ramREN, ramWEN};
            store_d = ramstore;
            cnt_d   = LAT4;
            state_d = (LAT == 0) ? ACCESS : BUSY;
        end

        // ACCESS lasts one cycle, so any transition into it is a completion edge.
        if (state_d == ACCESS) begin
            mem_we  = req_d[0];
            load_en = req_d[1];
        end
    end

    assign acc_idx = addr_d[AW+1:2];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FREE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            req_q   <= '0;
            store_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            store_q <= store_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) mem[acc_idx] <= store_d;
    end

    // Registered read port; holds its value through every cycle that is not a read completion.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)        load_q <= '0;
        else if (load_en) load_q <= mem[acc_idx];
    end

    assign ramload  = load_q;
    assign ramstate = state_q;

endmodule

// File: tb/tb_ram_latency_model.sv
// Scoreboard bench for ram_latency_model: a driver issues requests and queues expected
// completions from an array model; a negedge monitor pops and compares on ACCESS/ERROR.
`timescale 1ns/1ps
module tb_ram_latency_model;
    import cpu_types_pkg::*;

    localparam int DEPTH   = 8192;
    localparam int LAT     = 2;
    localparam int TIMEOUT = 40;

    logic        CLK  = 1'b0;
    logic        nRST = 1'b0;

    logic        ren   = 1'b0;
    logic        wen   = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] store = '0;
    logic [31:0] load;
    ramstate_t   state;

    logic        ren0   = 1'b0;
    logic        wen0   = 1'b0;
    logic [31:0] addr0  = '0;
    logic [31:0] store0 = '0;
    logic [31:0] load0;
    ramstate_t   state0;

    always #5 CLK = ~CLK;

    ram_latency_model #(.DEPTH(DEPTH), .LAT(LAT)) u_dut (
        .CLK(CLK), .nRST(nRST),
        .ramREN(ren), .ramWEN(wen), .ramaddr(addr), .ramstore(store),
        .ramload(load), .ramstate(state)
    );

    ram_latency_model #(.DEPTH(DEPTH), .LAT(0)) u_dut0 (
        .CLK(CLK), .nRST(nRST),
        .ramREN(ren0), .ramWEN(wen0), .ramaddr(addr0), .ramstore(store0),
        .ramload(load0), .ramstate(state0)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain word array plus the last value a read returned.
    logic [31:0] mem_m [DEPTH];
    logic [31:0] load_m;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        int          busy;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   busy_run = 0;

    function automatic int idx(input logic [31:0] a);
        return int'(a[31:2]);
    endfunction

    always @(negedge CLK) begin
        if (!nRST) begin
            busy_run = 0;
        end else if (state == BUSY) begin
            busy_run++;
        end else if (state == FREE) begin
            busy_run = 0;
        end else begin
            if (sb_q.size() == 0) begin
                check("unexpected_completion", 32'(state), 32'(FREE));
            end else begin
                mon_e = sb_q.pop_front();
                check("state", 32'(state), mon_e.is_err ? 32'(ERROR) : 32'(ACCESS));
                if (!mon_e.is_err) check("busy_cycles", 32'(busy_run), 32'(mon_e.busy));
                check("ramload", load, mon_e.data);
            end
            busy_run = 0;
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(state inside {ACCESS, ERROR}) && n < TIMEOUT);
        if (n >= TIMEOUT) begin
            checks++;
            failures++;
            $display("FAIL timeout: no completion after %0d cycles, required %0d", n, LAT + 1);
        end
    endtask

    task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   n;
        e.is_err = 1'b0;
        e.busy   = LAT;
        if (wr) begin
            mem_m[idx(a)] = d;
            e.data = load_m;
        end else begin
            load_m = mem_m[idx(a)];
            e.data = load_m;
        end
        sb_q.push_back(e);
        ren = !wr; wen = wr; addr = a; store = d;
        wait_done(n);
        check("latency", 32'(n), 32'(LAT + 1));
        ren = 1'b0; wen = 1'b0;
    endtask

    task automatic do_err(input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input int k);
        exp_t e;
        e.is_err = 1'b1;
        e.busy   = 0;
        e.data   = load_m;
        for (int i = 0; i < k; i++) sb_q.push_back(e);
        ren = r; wen = w; addr = a; store = d;
        repeat (k) @(negedge CLK);
        ren = 1'b0; wen = 1'b0;
        @(negedge CLK);
        check("free_after_error", 32'(state), 32'(FREE));
    endtask

    task automatic do_abort(input logic [31:0] a, input logic [31:0] d);
        wen = 1'b1; addr = a; store = d;
        @(negedge CLK);
        check("abort_busy", 32'(state), 32'(BUSY));
        wen = 1'b0;
        @(negedge CLK);
        check("abort_free", 32'(state), 32'(FREE));
        check("abort_load", load, load_m);
    endtask

    task automatic do_retarget(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
        exp_t e;
        int   n;
        e.is_err = 1'b0;
        e.busy   = LAT + 1;
        e.data   = load_m;
        mem_m[idx(b)] = d;
        sb_q.push_back(e);
        wen = 1'b1; addr = a; store = d;
        @(negedge CLK);
        check("retarget_busy", 32'(state), 32'(BUSY));
        addr = b;
        wait_done(n);
        check("retarget_latency", 32'(n), 32'(LAT + 1));
        wen = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acc;
        logic [31:0] a;
        logic [31:0] d;
        int          sel;

        foreach (mem_m[i]) mem_m[i] = '0;
        load_m = '0;

        @(negedge CLK);
        check("reset_state", 32'(state), 32'(FREE));
        check("reset_load", load, 32'h0);
        check("reset_state_lat0", 32'(state0), 32'(FREE));
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        check("idle_free", 32'(state), 32'(FREE));

        // Write then read back, LAT = 2.
        do_txn(1'b1, 32'h24, 32'h0000_BAAD);
        do_txn(1'b0, 32'h24, 32'h0);

        // Abort leaves memory untouched; retarget writes only the new address.
        do_abort(32'h40, 32'h1111);
        do_txn(1'b0, 32'h40, 32'h0);
        do_retarget(32'h50, 32'h54, 32'h2222);
        do_txn(1'b0, 32'h50, 32'h0);
        do_txn(1'b0, 32'h54, 32'h0);

        // Illegal requests: ERROR every held cycle, nothing modified.
        do_err(1'b1, 1'b1, 32'h24,   32'hFFFF_FFFF, 3);
        do_err(1'b0, 1'b1, 32'h22,   32'h5555, 2);
        do_err(1'b1, 1'b0, 32'h8000, 32'h0, 2);
        do_err(1'b0, 1'b1, 32'h8000, 32'h7777, 1);
        do_txn(1'b0, 32'h24, 32'h0);
        do_txn(1'b0, 32'h20, 32'h0);

        // Zero-latency instance.
        ren0 = 1'b1; addr0 = 32'h100;
        @(negedge CLK);
        check("lat0_access", 32'(state0), 32'(ACCESS));
        check("lat0_load_unwritten", load0, 32'h0);
        ren0 = 1'b0; wen0 = 1'b1; store0 = 32'h0000_CAFE;
        @(negedge CLK);
        check("lat0_write_access", 32'(state0), 32'(ACCESS));
        check("lat0_write_load", load0, 32'h0);
        wen0 = 1'b0; ren0 = 1'b1;
        acc = 0;
        repeat (6) begin
            @(negedge CLK);
            check("lat0_held_not_free", 32'(state0 == FREE), 32'h0);
            if (state0 == ACCESS) begin
                acc++;
                check("lat0_reread", load0, 32'h0000_CAFE);
            end
        end
        check("lat0_access_count", 32'(acc >= 3), 32'h1);
        addr0 = 32'h8000;
        @(negedge CLK);
        check("lat0_range_error", 32'(state0), 32'(ERROR));
        check("lat0_error_load", load0, 32'h0000_CAFE);
        ren0 = 1'b0;
        @(negedge CLK);
        check("lat0_free", 32'(state0), 32'(FREE));

        // Reset in the middle of a write.
        do_txn(1'b1, 32'h10, 32'h1234);
        wen = 1'b1; addr = 32'h10; store = 32'hDEAD;
        @(negedge CLK);
        check("rst_busy", 32'(state), 32'(BUSY));
        #2 nRST = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'(FREE));
        check("rst_load", load, 32'h0);
        load_m = '0;
        wen = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        do_txn(1'b0, 32'h10, 32'h0);

        // Randomised mix biased towards a small address pool for read-after-write hits.
        for (int t = 0; t < 300; t++) begin
            sel = int'($urandom_range(0, 19));
            a   = 32'($urandom_range(0, DEPTH - 1)) << 2;
            if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, 15)) << 2;
            d   = $urandom;
            if (sel < 9)        do_txn(1'b1, a, d);
            else if (sel < 18)  do_txn(1'b0, a, d);
            else if (sel == 18) do_err(1'b1, 1'b0, a | 32'($urandom_range(1, 3)), d,
                                       int'($urandom_range(1, 3)));
            else                do_err(1'b0, 1'b1, 32'($urandom_range(DEPTH, DEPTH + 100)) << 2,
                                       d, 1);
        end

        // Full-range sweep.
        for (int i = 0; i < DEPTH; i++) do_txn(1'b1, 32'(i) << 2, 32'(i));
        for (int i = 0; i < DEPTH; i++) do_txn(1'b0, 32'(i) << 2, 32'h0);

        repeat (3) @(negedge CLK);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
